mem_stage_ctrl: RTL and testbench

- Parametrised memory-stage unit with an integrated data memory and hardware stack engine.
- Executes single-word load, store, push and pop.
- Executes multi-beat CALL/INT/RET/RTI. These serialise a PC_W-bit PC, plus optional flags, into DATA_W-bit stack words, stalling the pipeline for the extra beats.
- Sits between EX/MEM and MEM/WB. Drives the WB fields and the reassembled PC/flags back to fetch.

---
 rtl/mem_stage_ctrl_if.sv | 53 +++++
 rtl/mem_stage_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Bus between the EX/MEM pipeline register, the memory stage and MEM/WB.
// Optional macro MEM_STACK_GUARD_EN adds the stack_err signal.
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned FLAG_W = 3
);
  logic              op_valid;
  logic [3:0]        op;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic [PC_W-1:0]   pc_in;
  logic [FLAG_W-1:0] flags_in;
  logic [2:0]        dst_in;
  logic              wb_in;
  logic              stall;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        dst_out;
  logic              wb_out;
  logic [PC_W-1:0]   pc_out;
  logic              pc_valid;
  logic [FLAG_W-1:0] flags_out;
  logic              flags_valid;
  logic [ADDR_W-1:0] sp_out;
`ifdef MEM_STACK_GUARD_EN
  logic              stack_err;

  modport master (
    output op_valid, op, addr_in, wdata, pc_in, flags_in, dst_in, wb_in,
    input  stall, data_out, dst_out, wb_out, pc_out, pc_valid, flags_out,
           flags_valid, sp_out, stack_err
  );

  modport slave (
    input  op_valid, op, addr_in, wdata, pc_in, flags_in, dst_in, wb_in,
    output stall, data_out, dst_out, wb_out, pc_out, pc_valid, flags_out,
           flags_valid, sp_out, stack_err
  );
`else
  modport master (
    output op_valid, op, addr_in, wdata, pc_in, flags_in, dst_in, wb_in,
    input  stall, data_out, dst_out, wb_out, pc_out, pc_valid, flags_out,
           flags_valid, sp_out
  );

  modport slave (
    input  op_valid, op, addr_in, wdata, pc_in, flags_in, dst_in, wb_in,
    output stall, data_out, dst_out, wb_out, pc_out, pc_valid, flags_out,
           flags_valid, sp_out
  );
`endif
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage: data memory plus hardware stack engine. Single-word
// LOAD/STORE/PUSH/POP and multi-beat CALL/INT/RET/RTI that serialise the PC
// (and flags) into stack words while stalling the pipeline.
// Optional macro MEM_STACK_GUARD_EN: stack over/underflow suppression and a
// sticky stack_err flag.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned FLAG_W    = 3,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned SP_INIT   = MEM_DEPTH - 1
) (
  input logic             clk,
  input logic             rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned BEATS = PC_W / DATA_W;
  localparam int unsigned CW    = $clog2(BEATS + 2);

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_PUSH  = 4'd3;
  localparam logic [3:0] OP_POP   = 4'd4;
  localparam logic [3:0] OP_CALL  = 4'd5;
  localparam logic [3:0] OP_INT   = 4'd6;
  localparam logic [3:0] OP_RET   = 4'd7;
  localparam logic [3:0] OP_RTI   = 4'd8;

  typedef enum logic {IDLE, XFER} state_e;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state;
  logic [CW-1:0]     beat_cnt;
  logic [AW-1:0]     sp;
  logic [3:0]        op_q;
  logic [PC_W-1:0]   pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic [PC_W-1:0]   pc_acc;
  logic [FLAG_W-1:0] flags_acc;
  logic [PC_W-1:0]   pc_out_q;
  logic              pc_valid_q;
  logic [FLAG_W-1:0] flags_out_q;
  logic              flags_valid_q;
`ifdef MEM_STACK_GUARD_EN
  logic              abort_q;
  logic              stack_err_q;
`endif

  logic [3:0]        cur_op;
  logic [PC_W-1:0]   cur_pc;
  logic [FLAG_W-1:0] cur_flags;
  logic [CW-1:0]     cur_beat;
  logic [CW-1:0]     n_beats;
  logic              active;
  logic              last_beat;
  logic              push_beat;
  logic              pop_beat;
  logic              guard_hit;
  logic              suppress;
  logic              do_push;
  logic              do_pop;
  logic              is_ret_op;
  logic              pop_is_flags;
  int unsigned       push_slice;
  int unsigned       pop_slice;
  logic [DATA_W-1:0] push_data;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wval;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rd;
  logic [PC_W-1:0]   pc_next;
  logic [FLAG_W-1:0] flags_next;
  logic              stall_c;
  logic              unused_addr;

  assign unused_addr = ^bus.addr_in[ADDR_W-1:AW];

  // Operation context: live inputs on the accepting beat, latched copy in XFER
  always_comb begin
    cur_op    = (state == XFER) ? op_q : bus.op;
    cur_pc    = (state == XFER) ? pc_q : bus.pc_in;
    cur_flags = (state == XFER) ? flags_q : bus.flags_in;
    cur_beat  = (state == XFER) ? beat_cnt : '0;
    active    = rst_n & ((state == XFER) | bus.op_valid);
    case (cur_op)
      OP_CALL, OP_RET: n_beats = CW'(BEATS);
      OP_INT, OP_RTI:  n_beats = CW'(BEATS + 1);
      default:         n_beats = CW'(1);
    endcase
    last_beat    = (cur_beat == n_beats - CW'(1));
    push_beat    = active & ((cur_op == OP_PUSH) | (cur_op == OP_CALL) | (cur_op == OP_INT));
    pop_beat     = active & ((cur_op == OP_POP) | (cur_op == OP_RET) | (cur_op == OP_RTI));
    is_ret_op    = (cur_op == OP_RET) | (cur_op == OP_RTI);
    pop_is_flags = (cur_op == OP_RTI) & (cur_beat == '0);
    stall_c      = active & (n_beats > CW'(1)) & ~last_beat;
  end

  // Stack guard: suppress a beat at the stack limits and all later beats of that op
  always_comb begin
`ifdef MEM_STACK_GUARD_EN
    guard_hit = (push_beat & (sp == '0)) | (pop_beat & (sp == AW'(SP_INIT)));
    suppress  = guard_hit | ((state == XFER) & abort_q);
`else
    guard_hit = 1'b0;
    suppress  = 1'b0;
`endif
    do_push = push_beat & ~suppress;
    do_pop  = pop_beat & ~suppress;
  end

  // Word selection for push beats: PC slices high to low, then flags
  always_comb begin
    push_slice = 0;
    if (32'(cur_beat) < BEATS) push_slice = BEATS - 32'(cur_beat) - 1;
    if (cur_op == OP_PUSH)
      push_data = bus.wdata;
    else if ((cur_op == OP_INT) && (32'(cur_beat) == BEATS))
      push_data = DATA_W'(cur_flags);
    else
      push_data = cur_pc[push_slice*DATA_W +: DATA_W];
  end

  // Memory port steering: one write and one combinational read per cycle
  always_comb begin
    we    = active & ((cur_op == OP_STORE) | do_push);
    waddr = (cur_op == OP_STORE) ? bus.addr_in[AW-1:0] : sp;
    wval  = (cur_op == OP_STORE) ? bus.wdata : push_data;
    raddr = (cur_op == OP_LOAD) ? bus.addr_in[AW-1:0] : sp + AW'(1);
    rd    = mem[raddr];
  end

  // Pop reassembly: flags first (RTI), then PC slices low to high
  always_comb begin
    if (cur_op == OP_RTI)
      pop_slice = (cur_beat == '0) ? 0 : 32'(cur_beat) - 1;
    else
      pop_slice = 32'(cur_beat);
    if (pop_slice >= BEATS) pop_slice = BEATS - 1;
    pc_next    = pc_acc;
    flags_next = flags_acc;
    if (do_pop && is_ret_op) begin
      if (pop_is_flags) flags_next = rd[FLAG_W-1:0];
      else              pc_next[pop_slice*DATA_W +: DATA_W] = rd;
    end
  end

  // Data memory write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wval;
  end

  // Control FSM, stack pointer, accumulators and registered fetch outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      sp            <= AW'(SP_INIT);
      op_q          <= '0;
      pc_q          <= '0;
      flags_q       <= '0;
      pc_acc        <= '0;
      flags_acc     <= '0;
      pc_out_q      <= '0;
      pc_valid_q    <= 1'b0;
      flags_out_q   <= '0;
      flags_valid_q <= 1'b0;
`ifdef MEM_STACK_GUARD_EN
      abort_q       <= 1'b0;
      stack_err_q   <= 1'b0;
`endif
    end else begin
      pc_valid_q    <= 1'b0;
      flags_valid_q <= 1'b0;
      if (active) begin
        if (state == IDLE) begin
          op_q    <= bus.op;
          pc_q    <= bus.pc_in;
          flags_q <= bus.flags_in;
        end
        if (do_push)     sp <= sp - AW'(1);
        else if (do_pop) sp <= sp + AW'(1);
        if (do_pop) begin
          pc_acc    <= pc_next;
          flags_acc <= flags_next;
        end
        if (last_beat) begin
          state    <= IDLE;
          beat_cnt <= '0;
          if (do_pop && is_ret_op) begin
            pc_out_q   <= pc_next;
            pc_valid_q <= 1'b1;
            if (cur_op == OP_RTI) begin
              flags_out_q   <= flags_next;
              flags_valid_q <= 1'b1;
            end
          end
        end else begin
          state    <= XFER;
          beat_cnt <= cur_beat + CW'(1);
        end
`ifdef MEM_STACK_GUARD_EN
        if (guard_hit) stack_err_q <= 1'b1;
        abort_q <= ~last_beat & (((state == XFER) & abort_q) | guard_hit);
`endif
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.data_out    = ((cur_op == OP_LOAD) || (cur_op == OP_POP)) ? rd : bus.wdata;
  assign bus.dst_out     = bus.dst_in;
  assign bus.wb_out      = bus.wb_in & bus.op_valid & ~stall_c;
  assign bus.pc_out      = pc_out_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.flags_out   = flags_out_q;
  assign bus.flags_valid = flags_valid_q;
  assign bus.sp_out      = ADDR_W'(sp);
`ifdef MEM_STACK_GUARD_EN
  assign bus.stack_err   = stack_err_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a reference stack/memory model and
// an expected-value queue for LOAD/POP data and RET/RTI results.
module tb_mem_stage_ctrl;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned SP_INIT   = 1023;
  localparam int unsigned BEATS     = PC_W / DATA_W;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_PUSH  = 4'd3;
  localparam logic [3:0] OP_POP   = 4'd4;
  localparam logic [3:0] OP_CALL  = 4'd5;
  localparam logic [3:0] OP_INT   = 4'd6;
  localparam logic [3:0] OP_RET   = 4'd7;
  localparam logic [3:0] OP_RTI   = 4'd8;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [15:0] mmem [MEM_DEPTH];
  logic [9:0]  sp_m;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .FLAG_W(FLAG_W)) bus ();

  mem_stage_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .FLAG_W(FLAG_W),
    .MEM_DEPTH(MEM_DEPTH), .SP_INIT(SP_INIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: observed 0x%0h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.addr_in  = '0;
    bus.wdata    = '0;
    bus.pc_in    = '0;
    bus.flags_in = '0;
    bus.dst_in   = '0;
    bus.wb_in    = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [15:0] wd,
                       input logic [31:0] pc, input logic [2:0] fl, input logic [2:0] dst,
                       input logic wb);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.addr_in  = addr;
    bus.wdata    = wd;
    bus.pc_in    = pc;
    bus.flags_in = fl;
    bus.dst_in   = dst;
    bus.wb_in    = wb;
  endtask

  // One-cycle op: model update, combinational checks mid-cycle, SP after the edge
  task automatic single(input logic [3:0] op, input logic [31:0] addr, input logic [15:0] wd,
                        input logic wb);
    logic [2:0] d;
    d = 3'(n_tests);
    drive(op, addr, wd, 32'h0, 3'd0, d, wb);
    case (op)
      OP_STORE: mmem[addr[9:0]] = wd;
      OP_LOAD:  expect_val("load_data", 32'(mmem[addr[9:0]]));
      OP_PUSH: begin mmem[sp_m] = wd; sp_m = sp_m - 10'd1; end
      OP_POP:  begin sp_m = sp_m + 10'd1; expect_val("pop_data", 32'(mmem[sp_m])); end
      default: ;
    endcase
    @(negedge clk);
    check("single_stall", 32'(bus.stall), 32'd0);
    check("single_wb_out", 32'(bus.wb_out), 32'(wb));
    check("single_dst_out", 32'(bus.dst_out), 32'(d));
    if (op == OP_LOAD || op == OP_POP) check_next(32'(bus.data_out));
    else                               check("pass_data", 32'(bus.data_out), 32'(wd));
    @(posedge clk); #1;
    idle_inputs();
    check("single_sp", bus.sp_out, 32'(sp_m));
  endtask

  // Multi-beat op: stall profile, input changes ignored after acceptance, result pulses
  task automatic multi(input logic [3:0] op, input logic [31:0] pc, input logic [2:0] fl);
    int n;
    logic [31:0] acc;
    logic [2:0]  fr;
    n   = (op == OP_CALL || op == OP_RET) ? BEATS : BEATS + 1;
    acc = '0;
    fr  = '0;
    drive(op, 32'h0, 16'h0, pc, fl, 3'd2, 1'b1);
    if (op == OP_CALL || op == OP_INT) begin
      for (int s = BEATS - 1; s >= 0; s--) begin mmem[sp_m] = pc[s*16 +: 16]; sp_m = sp_m - 10'd1; end
      if (op == OP_INT) begin mmem[sp_m] = 16'(fl); sp_m = sp_m - 10'd1; end
    end else begin
      if (op == OP_RTI) begin sp_m = sp_m + 10'd1; fr = mmem[sp_m][2:0]; end
      for (int s = 0; s < BEATS; s++) begin sp_m = sp_m + 10'd1; acc[s*16 +: 16] = mmem[sp_m]; end
      expect_val("pc_out", acc);
      if (op == OP_RTI) expect_val("flags_out", 32'(fr));
    end
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      check("multi_stall", 32'(bus.stall), 32'(b < n - 1));
      check("multi_wb_out", 32'(bus.wb_out), 32'(b == n - 1));
      check("multi_pc_valid_early", 32'(bus.pc_valid), 32'd0);
      @(posedge clk); #1;
      bus.pc_in    = ~pc;
      bus.flags_in = ~fl;
    end
    idle_inputs();
    if (op == OP_RET || op == OP_RTI) begin
      check_next(bus.pc_out);
      check("pc_valid_pulse", 32'(bus.pc_valid), 32'd1);
      if (op == OP_RTI) check_next(32'(bus.flags_out));
      check("flags_valid_pulse", 32'(bus.flags_valid), 32'(op == OP_RTI));
    end else begin
      check("push_no_pc_valid", 32'(bus.pc_valid), 32'd0);
    end
    check("multi_sp", bus.sp_out, 32'(sp_m));
    @(posedge clk); #1;
    check("pc_valid_one_cycle", 32'(bus.pc_valid), 32'd0);
    check("flags_valid_one_cycle", 32'(bus.flags_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_pc_valid", 32'(bus.pc_valid), 32'd0);
    check("rst_flags_valid", 32'(bus.flags_valid), 32'd0);
    check("rst_pc_out", bus.pc_out, 32'd0);
    check("rst_flags_out", 32'(bus.flags_out), 32'd0);
    check("rst_sp", bus.sp_out, 32'd1023);
`ifdef MEM_STACK_GUARD_EN
    check("rst_stack_err", 32'(bus.stack_err), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sp_m = 10'd1023;

    // Data memory load/store and pass-through
    single(OP_STORE, 32'd0, 16'h5A5A, 1'b0);
    single(OP_STORE, 32'd5, 16'hBEEF, 1'b1);
    single(OP_LOAD, 32'd5, 16'h0000, 1'b1);
    single(OP_LOAD, 32'd5, 16'h1234, 1'b0);
    single(OP_NOP, 32'd0, 16'h7777, 1'b1);

    // CALL then inspect stack words
    multi(OP_CALL, 32'h0001_2345, 3'd0);
    single(OP_LOAD, 32'd1023, 16'h0, 1'b1);
    single(OP_LOAD, 32'd1022, 16'h0, 1'b1);

    // INT, inspect, RTI, then RET back to the CALL frame
    multi(OP_INT, 32'hCAFE_0010, 3'b101);
    single(OP_LOAD, 32'd1021, 16'h0, 1'b1);
    single(OP_LOAD, 32'd1020, 16'h0, 1'b1);
    single(OP_LOAD, 32'd1019, 16'h0, 1'b1);
    multi(OP_RTI, 32'h0, 3'd0);
    multi(OP_RET, 32'h0, 3'd0);

    // Single-word stack ops
    single(OP_PUSH, 32'd0, 16'h1111, 1'b1);
    single(OP_PUSH, 32'd0, 16'h2222, 1'b1);
    single(OP_POP, 32'd0, 16'h0, 1'b1);
    single(OP_POP, 32'd0, 16'h0, 1'b1);

    // Reset during beat 0 of CALL aborts it
    drive(OP_CALL, 32'h0, 16'h0, 32'hDEAD_BEEF, 3'd0, 3'd1, 1'b1);
    @(negedge clk);
    check("call_beat0_stall", 32'(bus.stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(bus.stall), 32'd0);
    check("abort_sp", bus.sp_out, 32'd1023);
    check("abort_pc_valid", 32'(bus.pc_valid), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    check("abort_sp_hold", bus.sp_out, 32'd1023);
    check("abort_no_pulse", 32'(bus.pc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sp_m = 10'd1023;
    @(posedge clk); #1;
    multi(OP_CALL, 32'h0000_00AB, 3'd0);
    multi(OP_RET, 32'h0, 3'd0);

    // POP from an empty stack
`ifdef MEM_STACK_GUARD_EN
    drive(OP_POP, 32'h0, 16'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    idle_inputs();
    check("guard_stack_err", 32'(bus.stack_err), 32'd1);
    check("guard_sp", bus.sp_out, 32'd1023);
    @(posedge clk); #1;
    check("guard_sticky", 32'(bus.stack_err), 32'd1);
`else
    single(OP_POP, 32'd0, 16'h0, 1'b1);
    check("wrap_sp", bus.sp_out, 32'd0);
`endif

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
